// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - client-side handshake bundle of the frame-buffer arbiter
interface fb_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 12
);
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_rvalid;
    logic [DW-1:0] rd_rdata;

    modport master (
        output clr_start, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  clr_busy, clr_done, wr_ready, rd_ready, rd_rvalid, rd_rdata
    );

    modport slave (
        input  clr_start, wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output clr_busy, clr_done, wr_ready, rd_ready, rd_rvalid, rd_rdata
    );
endinterface

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - frame-buffer SRAM port owner: background clear plus read/write arbitration
module fb_arbiter #(
    parameter int            AW         = 12,
    parameter int            DW         = 12,
    parameter logic [DW-1:0] BG_COLOR   = 12'hCF0,
    parameter int            READ_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    fb_arbiter_if.slave   bus,
    output logic          FB_CEN,
    output logic          FB_WEN,
    output logic [AW-1:0] FB_A,
    output logic [DW-1:0] FB_D,
    input  logic [DW-1:0] FB_Q
);
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [3:0] RB = 4'(READ_BURST);

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic          clr_tail;
    logic [3:0]    rd_streak;
    logic [1:0]    rd_pend;
    logic          clr_busy_q;
    logic          clr_done_q;
    logic          rd_rvalid_q;

    logic          grant_ok;
    logic          rd_wins;
    logic          rd_gnt;
    logic          wr_gnt;

    // Reads win unless a write has been held off for READ_BURST consecutive reads.
    always_comb begin
        grant_ok = (state == RUN) && !bus.clr_start;
        rd_wins  = bus.rd_valid && !(bus.wr_valid && (rd_streak == RB));
        rd_gnt   = grant_ok && rd_wins;
        wr_gnt   = grant_ok && bus.wr_valid && !rd_wins;
    end

    assign bus.rd_ready  = rd_gnt;
    assign bus.wr_ready  = wr_gnt;
    assign bus.rd_rdata  = FB_Q;
    assign bus.rd_rvalid = rd_rvalid_q;
    assign bus.clr_busy  = clr_busy_q;
    assign bus.clr_done  = clr_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            clr_tail    <= 1'b0;
            clr_busy_q  <= 1'b1;
            clr_done_q  <= 1'b0;
            rd_streak   <= 4'd0;
            rd_pend     <= 2'b00;
            rd_rvalid_q <= 1'b0;
            FB_CEN      <= 1'b1;
            FB_WEN      <= 1'b1;
            FB_A        <= '0;
            FB_D        <= '0;
        end else begin
            clr_done_q  <= 1'b0;
            rd_pend     <= {rd_pend[0], rd_gnt};
            rd_rvalid_q <= rd_pend[1];

            if (!bus.wr_valid || wr_gnt) begin
                rd_streak <= 4'd0;
            end else if (rd_gnt && (rd_streak < RB)) begin
                rd_streak <= rd_streak + 4'd1;
            end

            case (state)
                CLEAR: begin
                    // One idle cycle after the last fill write keeps clients off the port until RUN.
                    if (clr_tail) begin
                        state      <= RUN;
                        clr_tail   <= 1'b0;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                        FB_CEN     <= 1'b1;
                        FB_WEN     <= 1'b1;
                    end else begin
                        FB_CEN   <= 1'b0;
                        FB_WEN   <= 1'b0;
                        FB_A     <= clr_cnt;
                        FB_D     <= BG_COLOR;
                        clr_cnt  <= clr_cnt + 1'b1;
                        clr_tail <= (clr_cnt == '1);
                    end
                end
                RUN: begin
                    if (bus.clr_start) begin
                        state      <= CLEAR;
                        clr_busy_q <= 1'b1;
                        FB_CEN     <= 1'b1;
                        FB_WEN     <= 1'b1;
                    end else if (rd_gnt) begin
                        FB_CEN <= 1'b0;
                        FB_WEN <= 1'b1;
                        FB_A   <= bus.rd_addr;
                    end else if (wr_gnt) begin
                        FB_CEN <= 1'b0;
                        FB_WEN <= 1'b0;
                        FB_A   <= bus.wr_addr;
                        FB_D   <= bus.wr_data;
                    end else begin
                        FB_CEN <= 1'b1;
                        FB_WEN <= 1'b1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - randomized and directed bench for fb_arbiter against a behavioural model
module tb_fb_arbiter;
    localparam logic [11:0] BG = 12'hCF0;
    localparam int          RB = 4;

    logic        clk;
    logic        reset;
    logic        fb_cen;
    logic        fb_wen;
    logic [11:0] fb_a;
    logic [11:0] fb_d;
    logic [11:0] fb_q;

    fb_arbiter_if #(.AW(12), .DW(12)) bus ();

    fb_arbiter #(.AW(12), .DW(12), .BG_COLOR(BG), .READ_BURST(RB)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .FB_CEN (fb_cen),
        .FB_WEN (fb_wen),
        .FB_A   (fb_a),
        .FB_D   (fb_d),
        .FB_Q   (fb_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM: access latched at the edge, read data lands on FB_Q one cycle later.
    logic [11:0] sram [4096];
    logic [11:0] q1;
    always @(posedge clk) begin
        if (!fb_cen) begin
            if (!fb_wen) sram[fb_a] <= fb_d;
            else         q1 <= sram[fb_a];
        end
        fb_q <= q1;
    end

    typedef struct {
        int          due;
        logic [11:0] data;
    } rd_exp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [11:0] mem_m [4096];
    rd_exp_t     rq [$];
    int          m_pos;
    int          m_streak;
    int          edge_no;
    int          done_edge;
    logic        e_cen, e_wen;
    logic [11:0] e_a, e_d;
    logic        obs_rd, obs_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: inputs were applied just after the previous edge.
    task automatic step();
        logic    exp_rd, exp_wr, exp_done;
        rd_exp_t r;
        #3;
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (m_pos == -1 && !bus.clr_start) begin
            if (bus.rd_valid && !(bus.wr_valid && m_streak == RB)) exp_rd = 1'b1;
            else if (bus.wr_valid)                                  exp_wr = 1'b1;
        end
        obs_rd = bus.rd_ready;
        obs_wr = bus.wr_ready;
        chk("rd_ready", obs_rd, exp_rd);
        chk("wr_ready", obs_wr, exp_wr);

        exp_done = 1'b0;
        if (m_pos >= 0 && m_pos < 4096) begin
            e_cen = 1'b0; e_wen = 1'b0; e_a = 12'(m_pos); e_d = BG;
            mem_m[m_pos] = BG;
            m_pos++;
        end else if (m_pos == 4096) begin
            e_cen = 1'b1; e_wen = 1'b1; m_pos = -1; exp_done = 1'b1;
        end else if (bus.clr_start) begin
            e_cen = 1'b1; e_wen = 1'b1; m_pos = 0;
        end else if (exp_rd) begin
            e_cen = 1'b0; e_wen = 1'b1; e_a = bus.rd_addr;
            r.due  = edge_no + 3;
            r.data = mem_m[bus.rd_addr];
            rq.push_back(r);
        end else if (exp_wr) begin
            e_cen = 1'b0; e_wen = 1'b0; e_a = bus.wr_addr; e_d = bus.wr_data;
            mem_m[bus.wr_addr] = bus.wr_data;
        end else begin
            e_cen = 1'b1; e_wen = 1'b1;
        end
        if (!bus.wr_valid || exp_wr) m_streak = 0;
        else if (exp_rd && m_streak < RB) m_streak++;

        @(posedge clk);
        edge_no++;
        #1;
        chk("FB_CEN", fb_cen, e_cen);
        chk("FB_WEN", fb_wen, e_wen);
        chk("FB_A", fb_a, e_a);
        chk("FB_D", fb_d, e_d);
        chk("clr_busy", bus.clr_busy, m_pos != -1);
        chk("clr_done", bus.clr_done, exp_done);
        if (bus.clr_done && done_edge < 0) done_edge = edge_no;
        if (rq.size() > 0 && rq[0].due == edge_no) begin
            chk("rd_rvalid", bus.rd_rvalid, 1);
            chk("rd_rdata", bus.rd_rdata, rq[0].data);
            void'(rq.pop_front());
        end else begin
            chk("rd_rvalid_idle", bus.rd_rvalid, 0);
        end
    endtask

    task automatic idle_inputs();
        bus.clr_start = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.rd_valid  = 1'b0;
    endtask

    // Called just after an edge; returns just after the edge where reset drops.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_FB_CEN", fb_cen, 1);
        chk("rst_FB_WEN", fb_wen, 1);
        chk("rst_FB_A", fb_a, 0);
        chk("rst_FB_D", fb_d, 0);
        chk("rst_clr_busy", bus.clr_busy, 1);
        chk("rst_clr_done", bus.clr_done, 0);
        chk("rst_rd_rvalid", bus.rd_rvalid, 0);
        chk("rst_rd_ready", bus.rd_ready, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_rvalid", bus.rd_rvalid, 0);
        end
        reset = 1'b0;
        rq.delete();
        m_pos = 0; m_streak = 0; edge_no = 0;
        e_cen = 1'b1; e_wen = 1'b1; e_a = '0; e_d = '0;
    endtask

    task automatic run_clear(input int base);
        int guard;
        guard = 0;
        done_edge = -1;
        while (done_edge < 0 && guard < 5000) begin
            step();
            guard++;
        end
        chk("clr_done_edge", done_edge - base, 4097);
    endtask

    task automatic check_mem_bg();
        int bad;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (sram[i] !== BG) bad++;
        chk("mem_all_bg", bad, 0);
    endtask

    function automatic logic [11:0] rand_addr();
        logic [11:0] a;
        a = 12'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) a = a - 12'd4;
        return a;
    endfunction

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_valid = 1'($urandom_range(0, 1));
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.rd_addr  = rand_addr();
            bus.wr_addr  = rand_addr();
            bus.wr_data  = 12'($urandom);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int n_w;
        reset = 1'b1;
        idle_inputs();
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Power-up clear
        run_clear(0);
        check_mem_bg();

        // Write then read back the same pixel
        bus.wr_valid = 1'b1; bus.wr_addr = 12'h041; bus.wr_data = 12'h0A5;
        step();
        bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_addr = 12'h041;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();

        // Continuous reads with a pending write: R,R,R,R,W
        n_w = 0;
        bus.rd_valid = 1'b1; bus.wr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.rd_addr = rand_addr(); bus.wr_addr = rand_addr(); bus.wr_data = 12'($urandom);
            step();
            if (obs_wr) n_w++;
        end
        chk("burst_writes", n_w, 4);
        idle_inputs();
        for (int i = 0; i < 3; i++) step();

        // Writes alone stream back to back
        n_w = 0;
        for (int i = 0; i < 10; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 12'(12'h100 + i); bus.wr_data = 12'($urandom);
            step();
            if (obs_wr) n_w++;
        end
        chk("write_stream", n_w, 10);
        idle_inputs();
        step();

        rand_phase(400);

        // Clear request with two reads in flight
        bus.rd_valid = 1'b1; bus.rd_addr = 12'h041;
        step();
        bus.rd_addr = 12'h100;
        step();
        bus.clr_start = 1'b1; bus.wr_valid = 1'b1; bus.wr_addr = 12'h055; bus.wr_data = 12'h123;
        step();
        bus.clr_start = 1'b0;
        run_clear(edge_no);
        check_mem_bg();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();

        // Reset while reads are streaming
        rand_phase(50);
        bus.rd_valid = 1'b1; bus.rd_addr = 12'h003;
        step();
        step();
        idle_inputs();
        do_reset();

        // Reset partway through the clear
        while (m_pos < 2000 && m_pos >= 0) step();
        chk("partial_clear_pos", fb_a, 12'd1999);
        do_reset();
        run_clear(0);
        check_mem_bg();
        rand_phase(100);
        for (int i = 0; i < 3; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
